led_matrix_capture: RTL and testbench

- Receiving end of the pong LED-matrix serial interface (RCLK/RSDI row chain, CCLK/CSDI column chain, LE latch, OEB blank).
- Deserialises both shift chains, models the latch and output-enable stage, and rebuilds the displayed frame from multiplexed row scans.
- Sits in the user project beside the pong core for loopback self-test, and in benches as a synthesisable frame checker.
- Exposes the last complete frame through a registered row-read port, plus a frame counter and a protocol-error flag.

---
 rtl/led_matrix_capture.sv | 143 ++++++++++++++
 tb/tb_led_matrix_capture.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_capture.sv
// Receiver for the pong LED-matrix serial link: deserialises the row/column
// chains, models latch + output enable, and rebuilds the displayed frame.
module led_matrix_capture #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int RW     = 3,
  parameter int MIN_ON = 2
) (
  input  logic            clock,
  input  logic            resetb,
  input  logic            rclk,
  input  logic            rsdi,
  input  logic            cclk,
  input  logic            csdi,
  input  logic            le,
  input  logic            oeb,
  input  logic [RW-1:0]   rd_row,
  output logic [COLS-1:0] rd_data,
  output logic            frame_valid,
  output logic [15:0]     frame_count,
  output logic            err_onehot,
  input  logic            err_clr
);

  localparam int CW = $clog2(MIN_ON + 1);

  // Pin order: 0 rclk, 1 rsdi, 2 cclk, 3 csdi, 4 le, 5 oeb
  logic [5:0] sync1, sync2;
  logic [2:0] edge_d;            // third flop for rclk, cclk, le only
  logic       rclk_rise, cclk_rise, le_rise, oeb_s;

  logic [ROWS-1:0]            row_sr, row_lat;
  logic [COLS-1:0]            col_sr, col_lat;
  logic [CW-1:0]              on_cnt;
  logic [ROWS-1:0][COLS-1:0]  acc, frame;
  logic [RW-1:0]              prev_row;
  logic                       prev_valid;

  logic          sr_oh, lat_oh, shown, commit;
  logic [RW-1:0] sr_k, lat_k;

  always_ff @(posedge clock) begin
    if (!resetb) begin
      sync1  <= '0;
      sync2  <= '0;
      edge_d <= '0;
    end else begin
      sync1  <= {oeb, le, csdi, cclk, rsdi, rclk};
      sync2  <= sync1;
      edge_d <= {sync2[4], sync2[2], sync2[0]};
    end
  end

  assign rclk_rise = sync2[0] & ~edge_d[0];
  assign cclk_rise = sync2[2] & ~edge_d[1];
  assign le_rise   = sync2[4] & ~edge_d[2];
  assign oeb_s     = sync2[5];

  always_comb begin
    sr_k  = '0;
    lat_k = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (row_sr[i])  sr_k  = RW'(i);
      if (row_lat[i]) lat_k = RW'(i);
    end
  end

  assign sr_oh  = $onehot(row_sr);
  assign lat_oh = $onehot(row_lat);
  assign shown  = (on_cnt == CW'(MIN_ON)) && !oeb_s;
  assign commit = le_rise && sr_oh && prev_valid && (sr_k <= prev_row);

  // Latch captures pre-shift contents when a shift edge lands on the same cycle.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      row_sr  <= '0;
      col_sr  <= '0;
      row_lat <= '0;
      col_lat <= '0;
    end else begin
      if (rclk_rise) row_sr <= {row_sr[ROWS-2:0], sync2[1]};
      if (cclk_rise) col_sr <= {col_sr[COLS-2:0], sync2[3]};
      if (le_rise) begin
        row_lat <= row_sr;
        col_lat <= col_sr;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetb)
      on_cnt <= '0;
    else if (le_rise || oeb_s)
      on_cnt <= '0;
    else if (on_cnt != CW'(MIN_ON))
      on_cnt <= on_cnt + 1'b1;
  end

  // Commit clears acc after the accumulate, so a same-cycle accumulation is lost.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      acc         <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
      frame_count <= '0;
      prev_row    <= '0;
      prev_valid  <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (shown && lat_oh)
        acc[lat_k] <= acc[lat_k] | col_lat;
      if (commit) begin
        frame       <= acc;
        acc         <= '0;
        frame_valid <= 1'b1;
        frame_count <= frame_count + 16'd1;
      end
      if (le_rise && sr_oh) begin
        prev_row   <= sr_k;
        prev_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetb)
      err_onehot <= 1'b0;
    else if (le_rise && !sr_oh)
      err_onehot <= 1'b1;
    else if (err_clr)
      err_onehot <= 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!resetb)
      rd_data <= '0;
    else if (int'(rd_row) < ROWS)
      rd_data <= frame[rd_row];
    else
      rd_data <= '0;
  end

endmodule

// File: tb/tb_led_matrix_capture.sv
// Scoreboard bench for led_matrix_capture: stimulus pushes expected readouts
// and commit counts; monitors pop and compare when the DUT presents them.
module tb_led_matrix_capture;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int RW   = 3;

  logic            clock = 1'b0;
  logic            resetb = 1'b0;
  logic            rclk = 1'b0, rsdi = 1'b0, cclk = 1'b0, csdi = 1'b0;
  logic            le = 1'b0, oeb = 1'b1, err_clr = 1'b0;
  logic [RW-1:0]   rd_row = '0;
  logic [COLS-1:0] rd_data;
  logic            frame_valid;
  logic [15:0]     frame_count;
  logic            err_onehot;

  int checks = 0;
  int failures = 0;

  logic [COLS-1:0] rd_q[$];
  logic [15:0]     fv_q[$];
  logic            rd_req = 1'b0, rd_req_d = 1'b0;

  led_matrix_capture #(.ROWS(ROWS), .COLS(COLS), .RW(RW), .MIN_ON(2)) dut (
    .clock(clock), .resetb(resetb), .rclk(rclk), .rsdi(rsdi), .cclk(cclk),
    .csdi(csdi), .le(le), .oeb(oeb), .rd_row(rd_row), .rd_data(rd_data),
    .frame_valid(frame_valid), .frame_count(frame_count),
    .err_onehot(err_onehot), .err_clr(err_clr)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge clock) rd_req_d <= rd_req;

  always @(negedge clock) begin
    if (rd_req_d) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 32'(rd_data), 32'hDEAD);
      else chk("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
    end
    if (frame_valid) begin
      if (fv_q.size() == 0) chk("fv_unexpected", 32'(frame_count), 32'hDEAD);
      else chk("frame_count", 32'(frame_count), 32'(fv_q.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send(input logic [ROWS-1:0] r, input logic [COLS-1:0] c);
    for (int i = ROWS - 1; i >= 0; i--) begin
      rsdi = r[i];
      csdi = c[i];
      tick(1);
      rclk = 1'b1; cclk = 1'b1;
      tick(2);
      rclk = 1'b0; cclk = 1'b0;
      tick(1);
    end
  endtask

  task automatic pulse_le();
    le = 1'b1; tick(2);
    le = 1'b0; tick(2);
  endtask

  task automatic show(input int n);
    oeb = 1'b0; tick(n);
    oeb = 1'b1; tick(3);
  endtask

  task automatic scan_row(input int k, input logic [COLS-1:0] c, input int n);
    send(ROWS'(1) << k, c);
    pulse_le();
    show(n);
  endtask

  task automatic read_row(input int r, input logic [COLS-1:0] exp);
    rd_row = RW'(r);
    rd_req = 1'b1;
    rd_q.push_back(exp);
    tick(1);
    rd_req = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1; tick(1);
    err_clr = 1'b0;
  endtask

  initial begin
    tick(3);
    // reset state
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_err", 32'(err_onehot), 0);
    chk("rst_frame_valid", 32'(frame_valid), 0);
    resetb = 1'b1;
    tick(2);
    read_row(0, 8'h00);
    tick(2);

    // full scan, wrap back to row 0 commits
    for (int k = 0; k < ROWS; k++) scan_row(k, 8'hA5, 4);
    fv_q.push_back(16'd1);
    scan_row(0, 8'hA5, 4);
    for (int r = 0; r < ROWS; r++) read_row(r, 8'hA5);
    tick(2);

    // row 3 shown for too short a time
    for (int k = 1; k < ROWS; k++) scan_row(k, 8'hA5, (k == 3) ? 1 : 4);
    fv_q.push_back(16'd2);
    scan_row(0, 8'hA5, 4);
    for (int r = 0; r < ROWS; r++) read_row(r, (r == 3) ? 8'h00 : 8'hA5);
    tick(2);

    // multi-hot row mid-scan: error, no commit, no accumulation
    scan_row(1, 8'hA5, 4);
    scan_row(2, 8'hA5, 4);
    send(8'h03, 8'hFF);
    pulse_le();
    show(4);
    chk("err_set", 32'(err_onehot), 1);
    pulse_clr();
    chk("err_clr", 32'(err_onehot), 0);
    for (int k = 3; k < ROWS; k++) scan_row(k, 8'hA5, 4);
    fv_q.push_back(16'd3);
    scan_row(0, 8'hA5, 4);
    for (int r = 0; r < ROWS; r++) read_row(r, 8'hA5);
    tick(2);

    // le and cclk rising on the same cycle
    send(8'h00, 8'h0F);
    csdi = 1'b1;
    tick(1);
    le = 1'b1; cclk = 1'b1;
    tick(2);
    le = 1'b0; cclk = 1'b0;
    tick(2);
    chk("sim_col_lat", 32'(dut.col_lat), 32'h0F);
    chk("sim_col_sr", 32'(dut.col_sr), 32'h1F);
    chk("sim_err_zero_row", 32'(err_onehot), 1);
    pulse_clr();

    // reset mid-scan
    fv_q.push_back(16'd4);
    for (int k = 0; k < 5; k++) scan_row(k, 8'hA5, 4);
    resetb = 1'b0;
    tick(3);
    resetb = 1'b1;
    tick(2);
    chk("rst2_frame_count", 32'(frame_count), 0);
    read_row(0, 8'h00);
    read_row(2, 8'h00);
    for (int k = 0; k < ROWS; k++) scan_row(k, 8'hFF, 4);
    chk("pre_wrap_count", 32'(frame_count), 0);
    fv_q.push_back(16'd1);
    scan_row(0, 8'hFF, 4);
    for (int r = 0; r < ROWS; r++) read_row(r, 8'hFF);
    tick(2);

    // frame counter wraps
    force dut.frame_count = 16'hFFFF;
    tick(1);
    release dut.frame_count;
    fv_q.push_back(16'h0000);
    scan_row(0, 8'h3C, 4);
    read_row(0, 8'hFF);
    read_row(1, 8'h00);
    read_row(7, 8'h00);
    tick(5);

    chk("rd_q_drained", 32'(rd_q.size()), 0);
    chk("fv_q_drained", 32'(fv_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
